onehot_serial_encoder: RTL and testbench



---
 rtl/onehot_serial_encoder_pkg.sv | 29 ++
 rtl/onehot_serial_encoder_lsb_priority_enc.sv | 16 +
 rtl/onehot_serial_encoder.sv | 112 +++++++++++
 tb/tb_onehot_serial_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_serial_encoder_pkg.sv
// Shared types and bit-scan helpers for the one-hot serial encoder.
// Helpers work on a MAX_W-bit word; callers zero-extend narrower words and truncate results.
package onehot_enc_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_EMIT = 2'd1,
        ENC_ERR  = 2'd2
    } enc_state_t;

    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_W-1:0] word);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [MAX_W-1:0] word);
        return (word != '0) && ((word & (word - MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_serial_encoder_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder; o_idx is 0 and o_any is 0 for an all-zero word.
module lsb_priority_enc
    import onehot_enc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_word,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    assign o_idx = IDX_W'(lowest_set_idx(MAX_W'(i_word)));
    assign o_any = |i_word;

endmodule

// File: rtl/onehot_serial_encoder.sv
// onehot_serial_encoder: emits set-bit indices lowest first; ONEHOT_STRICT_EN rejects multi-hot words.
// First beat one cycle after accept; out_* hold while out_ready is low; in_ready only when idle.
module onehot_serial_encoder
    import onehot_enc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_seq,
    output logic             out_last,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEQ_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = ENC_IDLE;
    localparam logic [1:0] ST_EMIT = ENC_EMIT;
    localparam logic [1:0] ST_ERR  = ENC_ERR;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pending;
    logic [SEQ_W-1:0] r_seq;

    logic [IDX_W-1:0] w_low_idx;
    logic             w_any;
    logic             w_single;
    logic             w_accept_err;
    logic             w_emit;
    logic             w_err;

    lsb_priority_enc #(
        .WIDTH (WIDTH)
    ) u_lsb_enc (
        .i_word (r_pending),
        .o_idx  (w_low_idx),
        .o_any  (w_any)
    );

    assign w_single = is_single(MAX_W'(r_pending));

`ifdef ONEHOT_STRICT_EN
    assign w_accept_err = !is_single(MAX_W'(in_word));
`else
    assign w_accept_err = (in_word == '0);
`endif

    // EMIT with nothing pending cannot be reached; gating on w_any keeps a corrupted state silent.
    assign w_emit = (r_state == ST_EMIT) && w_any;
    assign w_err  = (r_state == ST_ERR);

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = w_emit || w_err;
        out_idx   = '0;
        out_seq   = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        if (w_emit) begin
            out_idx  = w_low_idx;
            out_seq  = r_seq;
            out_last = w_single;
        end else if (w_err) begin
            out_last = 1'b1;
            out_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_seq     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_pending <= in_word;
                        r_seq     <= '0;
                        r_state   <= w_accept_err ? ST_ERR : ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready || !w_any) begin
                        // Clearing the lowest set bit needs no decode of w_low_idx.
                        r_pending <= r_pending & (r_pending - WIDTH'(1));
                        r_seq     <= r_seq + SEQ_W'(1);
                        if (w_single || !w_any) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Scoreboard bench for onehot_serial_encoder at WIDTH=4; expected beats come from a bit-walk model.
module tb_onehot_serial_encoder;

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] seq;
        logic       last;
        logic       err;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_word;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_idx;
    logic [2:0] out_seq;
    logic       out_last;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    onehot_serial_encoder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_seq   (out_seq),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic beat_t cur_beat();
        beat_t b;
        b.idx  = out_idx;
        b.seq  = out_seq;
        b.last = out_last;
        b.err  = out_err;
        return b;
    endfunction

    task automatic push_model(input logic [3:0] w);
        beat_t b;
        int    n    = 0;
        int    seen = 0;
        logic  bad;
        for (int i = 0; i < 4; i++) n += int'(w[i]);
`ifdef ONEHOT_STRICT_EN
        bad = (n != 1);
`else
        bad = (n == 0);
`endif
        if (bad) begin
            b = '{idx: 2'd0, seq: 3'd0, last: 1'b1, err: 1'b1};
            q.push_back(b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) begin
                    b.idx  = i[1:0];
                    b.seq  = seen[2:0];
                    b.last = (seen == n - 1);
                    b.err  = 1'b0;
                    q.push_back(b);
                    seen++;
                end
            end
        end
    endtask

    // Leaves the caller at the negedge where the first beat should be visible.
    task automatic send(input logic [3:0] w);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready word=%b got=%b want=1", w, in_ready);
        end
        in_word  = w;
        in_valid = 1'b1;
        push_model(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_word   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (cur_beat() !== beat_t'(0)) begin
            errors++;
            $display("FAIL reset_out_fields got=%b want=%b", cur_beat(), beat_t'(0));
        end
    endtask

    task automatic test_words(input logic [3:0] w, input string name);
        beat_t exp;
        out_ready = 1'b1;
        send(w);
        for (int c = 0; c < 12 && q.size() > 0; c++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid cycle=%0d got=%b want=1", name, c, out_valid);
            end else begin
                exp = q.pop_front();
                checks++;
                if (cur_beat() !== exp) begin
                    errors++;
                    $display("FAIL %s_beat got=%b want=%b (idx,seq,last,err)", name, cur_beat(), exp);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_in_ready_busy got=%b want=0", name, in_ready);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d want=0", name, q.size());
            q.delete();
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s_idle got in_ready,out_valid=%b want=10", name, {in_ready, out_valid});
        end
    endtask

    task automatic test_backpressure();
        beat_t held;
        beat_t exp;
        out_ready = 1'b0;
        send(4'b0110);
        held     = cur_beat();
        in_word  = 4'b1111;
        in_valid = 1'b1;
        checks++;
        if (held !== beat_t'({2'd1, 3'd0, 1'b0, 1'b0}) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got=%b valid=%b want=0100000 valid=1", held, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (cur_beat() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got=%b valid=%b rdy=%b want=%b valid=1 rdy=0",
                         c, cur_beat(), out_valid, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = q.pop_front();
                checks++;
                if (cur_beat() !== exp) begin
                    errors++;
                    $display("FAIL bp_beat got=%b want=%b", cur_beat(), exp);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_timeout pending=%0d want=0", q.size());
            q.delete();
        end
        repeat (2) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL bp_ignored_word got in_ready,out_valid=%b want=10", {in_ready, out_valid});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        beat_t exp;
        out_ready = 1'b1;
        send(4'b1111);
        for (int c = 0; c < 2; c++) begin
            exp = q.pop_front();
            checks++;
            if (cur_beat() !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL abort_beat%0d got=%b valid=%b want=%b valid=1", c, cur_beat(), out_valid, exp);
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL abort_async got in_ready,out_valid=%b want=10", {in_ready, out_valid});
        end
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_beats cycle=%0d got out_valid=%b want=0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_words(4'b0100, "single");
        test_words(4'b1011, "multi");
        test_words(4'b0000, "zero");
`ifdef ONEHOT_STRICT_EN
        test_words(4'b0011, "strict_multi");
        test_words(4'b1000, "strict_one");
`else
        test_words(4'b1111, "full");
`endif
        test_backpressure();
        test_reset_abort();
        test_words(4'b1001, "after_abort");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
